// File: rtl/ysyx_rnu_freelist_pkg.sv
// Default register-index widths shared by the rename unit.
package ysyx_rnu_freelist_pkg;
  localparam int YSYX_PHY_LEN = 6;
  localparam int YSYX_REG_LEN = 5;
endpackage

// File: rtl/ysyx_rnu_freelist.sv
// Physical register free list: circular flop array with speculative head,
// committed head and tail pointers; flush rolls speculation back to cmt_head.
module ysyx_rnu_freelist
  import ysyx_rnu_freelist_pkg::*;
#(
  parameter int PLEN = YSYX_PHY_LEN,
  parameter int RLEN = YSYX_REG_LEN
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             alloc_ready,
  output logic                             alloc_valid,
  output logic [PLEN-1:0]                  alloc_prd,
  input  logic                             cmt_valid,
  input  logic [PLEN-1:0]                  cmt_prs,
  input  logic                             flush,
  output logic [$clog2((2**PLEN-2**RLEN)+1)-1:0] free_cnt,
  output logic                             err
);

  localparam int DEPTH = 2**PLEN - 2**RLEN;
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [PLEN-1:0] r_array [DEPTH];
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_cmt_head;
  logic [PW-1:0]   r_tail;
  logic [CW-1:0]   r_free_cnt;
  logic            r_err;

  logic            w_fire;
  logic            w_cmt_ok;
  logic            w_cmt_bad;
  logic [PW-1:0]   w_cmt_head_nxt;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign w_fire         = (r_free_cnt != '0) && alloc_ready && !flush;
  assign w_cmt_ok       = cmt_valid && (r_free_cnt != CW'(DEPTH)) && (cmt_prs != '0);
  assign w_cmt_bad      = cmt_valid && !w_cmt_ok;
  assign w_cmt_head_nxt = w_cmt_ok ? f_inc(r_cmt_head) : r_cmt_head;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_array[i[PW-1:0]] <= PLEN'(2**RLEN + i);
      end
      r_head     <= '0;
      r_cmt_head <= '0;
      r_tail     <= '0;
      r_free_cnt <= CW'(DEPTH);
      r_err      <= 1'b0;
    end else begin
      if (w_cmt_ok) begin
        r_array[r_tail] <= cmt_prs;
        r_tail          <= f_inc(r_tail);
      end
      r_cmt_head <= w_cmt_head_nxt;
      // tail and cmt_head move in lockstep, so nothing committed is still
      // outstanding after a squash: the whole ring becomes allocatable.
      if (flush) begin
        r_head     <= w_cmt_head_nxt;
        r_free_cnt <= CW'(DEPTH);
      end else begin
        if (w_fire) r_head <= f_inc(r_head);
        case ({w_fire, w_cmt_ok})
          2'b10:   r_free_cnt <= r_free_cnt - 1'b1;
          2'b01:   r_free_cnt <= r_free_cnt + 1'b1;
          default: r_free_cnt <= r_free_cnt;
        endcase
      end
      if (w_cmt_bad) r_err <= 1'b1;
    end
  end

  assign alloc_valid = (r_free_cnt != '0);
  assign alloc_prd   = r_array[r_head];
  assign free_cnt    = r_free_cnt;
  assign err         = r_err;

endmodule
